// File: rtl/spike_pattern_serializer.sv
// Temporal spike pattern serializer: replays a T_WINDOW-bit
// pattern as one spike per consumed timestep, earliest bit first.
module spike_pattern_serializer #(
   parameter int T_WINDOW   = 16,
   parameter bit SKIP_EMPTY = 1'b1,
   parameter int CNT_W      = $clog2(T_WINDOW + 1),
   localparam int IW        = $clog2(T_WINDOW)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [T_WINDOW-1:0] pattern_in,
   input  logic                pattern_valid,
   output logic                pattern_ready,
   input  logic                step_en,
   output logic                spike_out,
   output logic                spike_valid,
   output logic [IW-1:0]       step_idx,
   output logic [CNT_W-1:0]    spike_count,
   output logic                window_done,
   output logic                busy
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [T_WINDOW-1:0] shreg;
   logic                pend;
   logic                last;
   logic                accept;
   logic                zero;
   logic                skip;
   logic                start;
   logic                consume;

   localparam logic [IW-1:0] LAST_IDX = IW'(T_WINDOW - 1);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state, handshake and window events
   always_comb begin
      state_nx      = state;
      busy          = 1'b0;
      spike_valid   = 1'b0;
      consume       = 1'b0;
      last          = 1'b0;
      pattern_ready = 1'b0;
      unique case (state)
         IDLE: begin
            pattern_ready = 1'b1;
         end
         SHIFT: begin
            busy          = 1'b1;
            spike_valid   = 1'b1;
            consume       = step_en;
            last          = step_en && (step_idx == LAST_IDX);
            pattern_ready = last;
         end
         default: state_nx = IDLE;
      endcase
      accept = pattern_valid && pattern_ready;
      zero   = (pattern_in == '0);
      skip   = accept && zero && SKIP_EMPTY;
      start  = accept && !(zero && SKIP_EMPTY);
      if (start)     state_nx = SHIFT;
      else if (last) state_nx = IDLE;
   end

   assign spike_out = spike_valid && shreg[0];

   // Shift register, step index, spike count and done pulses.
   // A zero pattern skipped while another pulse is due is queued
   // in pend so each window still gets its own done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg       <= '0;
         step_idx    <= '0;
         spike_count <= '0;
         window_done <= 1'b0;
         pend        <= 1'b0;
      end else begin
         window_done <= last || pend || skip;
         pend        <= skip && (last || pend);
         if (start)        shreg <= pattern_in;
         else if (consume) shreg <= shreg >> 1;
         if (start)        step_idx <= '0;
         else if (consume) step_idx <= last ? '0 : step_idx + IW'(1);
         if (start)
            spike_count <= '0;
         else if (consume)
            spike_count <= spike_count + CNT_W'(shreg[0]);
         else if (skip || pend)
            spike_count <= '0;
      end
   end

endmodule
